// File: rtl/sd_cmd_sequencer_if.sv
// Requester and phy-side signal bundle for the SD command sequencer.
// The slave modport is the sequencer; the master modport is the requester/phy side.
interface sd_cmd_sequencer_if #(
    parameter int unsigned CMD_W  = 38,
    parameter int unsigned RESP_W = 38
);
    logic [1:0]        iReq;
    logic [CMD_W-1:0]  iCmd0;
    logic [CMD_W-1:0]  iCmd1;
    logic [1:0]        oGrant;
    logic [1:0]        oDone;
    logic              oTimeout;
    logic [RESP_W-1:0] oResponse;
    logic              oStrobe_in;
    logic [CMD_W-1:0]  oCommand;
    logic              oAck_in;
    logic              oIdle_in;
    logic              iAck_out;
    logic              iCommand_timeout;
    logic [RESP_W-1:0] iResponse;

    modport slave (
        input  iReq, iCmd0, iCmd1, iAck_out, iCommand_timeout, iResponse,
        output oGrant, oDone, oTimeout, oResponse, oStrobe_in, oCommand, oAck_in, oIdle_in
    );

    modport master (
        output iReq, iCmd0, iCmd1, iAck_out, iCommand_timeout, iResponse,
        input  oGrant, oDone, oTimeout, oResponse, oStrobe_in, oCommand, oAck_in, oIdle_in
    );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// Arbitrates two requesters onto the SD phy command block, runs the strobe/ack
// handshake with a watchdog abort, and returns the captured response to the winner.
module sd_cmd_sequencer #(
    parameter int unsigned CMD_W       = 38,
    parameter int unsigned RESP_W      = 38,
    parameter int unsigned WDOG_CYCLES = 256,
    parameter int unsigned WDOG_W      = 9
) (
    input  logic               iClock_SD,
    input  logic               iReset,
    sd_cmd_sequencer_if.slave  bus
);

    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        RELEASE,
        ABORT,
        DONE
    } seqState_t;

    seqState_t         state;
    logic [WDOG_W-1:0] wdog;
    logic              rrLast;
    logic              grantIdx;
    logic              tflag;
    logic              pickIdx;

    // Requester 1 wins when alone, or when both ask and requester 0 went last.
    assign pickIdx = bus.iReq[1] & (~bus.iReq[0] | ~rrLast);

    always_ff @(posedge iClock_SD) begin
        if (iReset) begin
            state          <= IDLE;
            wdog           <= '0;
            rrLast         <= 1'b1;
            grantIdx       <= 1'b0;
            tflag          <= 1'b0;
            bus.oGrant     <= 2'b00;
            bus.oDone      <= 2'b00;
            bus.oTimeout   <= 1'b0;
            bus.oResponse  <= RESP_W'(0);
            bus.oStrobe_in <= 1'b0;
            bus.oCommand   <= CMD_W'(0);
            bus.oAck_in    <= 1'b0;
            bus.oIdle_in   <= 1'b0;
        end else begin
            bus.oDone    <= 2'b00;
            bus.oTimeout <= 1'b0;
            bus.oIdle_in <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.iReq != 2'b00) begin
                        grantIdx     <= pickIdx;
                        bus.oGrant   <= pickIdx ? 2'b10 : 2'b01;
                        bus.oCommand <= pickIdx ? bus.iCmd1 : bus.iCmd0;
                        wdog         <= '0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.oStrobe_in <= 1'b1;
                    // Phy timeout outranks a coincident ack.
                    if (bus.iCommand_timeout) begin
                        bus.oResponse <= RESP_W'(0);
                        tflag         <= 1'b1;
                        state         <= RELEASE;
                    end else if (bus.iAck_out) begin
                        bus.oResponse <= bus.iResponse;
                        tflag         <= 1'b0;
                        state         <= RELEASE;
                    end else if (wdog == WDOG_LAST) begin
                        tflag <= 1'b1;
                        state <= ABORT;
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                    end
                end
                RELEASE: begin
                    bus.oStrobe_in <= 1'b0;
                    if (bus.iAck_out) begin
                        bus.oAck_in <= 1'b1;
                    end else begin
                        bus.oAck_in <= 1'b0;
                        state       <= DONE;
                    end
                end
                ABORT: begin
                    bus.oStrobe_in <= 1'b0;
                    bus.oIdle_in   <= 1'b1;
                    bus.oResponse  <= RESP_W'(0);
                    state          <= DONE;
                end
                DONE: begin
                    bus.oDone    <= grantIdx ? 2'b10 : 2'b01;
                    bus.oTimeout <= tflag;
                    rrLast       <= grantIdx;
                    bus.oGrant   <= 2'b00;
                    wdog         <= '0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed bench for sd_cmd_sequencer: reset, arbitration, handshake latency,
// phy timeout, watchdog abort and requester withdrawal.
module tb_sd_cmd_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    sd_cmd_sequencer_if #(.CMD_W(38), .RESP_W(38)) bus ();

    sd_cmd_sequencer #(
        .CMD_W(38), .RESP_W(38), .WDOG_CYCLES(16), .WDOG_W(5)
    ) dut (
        .iClock_SD(clk),
        .iReset   (rst),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitStrobe(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus.oStrobe_in === 1'b1) found = 1'b1;
        end
        chk({tag, "_strobe_seen"}, 64'(found), 64'd1);
    endtask

    task automatic complete(input string tag, input logic [1:0] expDone, input logic [37:0] resp);
        bit seen;
        seen = 1'b0;
        bus.iAck_out  = 1'b1;
        bus.iResponse = resp;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (bus.oAck_in === 1'b1) seen = 1'b1;
        end
        chk({tag, "_ack_in_seen"}, 64'(seen), 64'd1);
        chk({tag, "_strobe_low"}, 64'(bus.oStrobe_in), 64'd0);
        bus.iAck_out = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (bus.oDone !== 2'b00) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_done"}, 64'(bus.oDone), 64'(expDone));
        chk({tag, "_timeout"}, 64'(bus.oTimeout), 64'd0);
        chk({tag, "_response"}, 64'(bus.oResponse), 64'(resp));
    endtask

    task automatic serve(input string tag, input logic [1:0] expGrant, input logic [37:0] expCmd,
                         input logic [37:0] resp);
        waitStrobe(tag);
        chk({tag, "_grant"}, 64'(bus.oGrant), 64'(expGrant));
        chk({tag, "_command"}, 64'(bus.oCommand), 64'(expCmd));
        complete(tag, expGrant, resp);
    endtask

    initial begin
        logic [37:0] cmdA;
        logic [37:0] cmdB;
        int          cnt;
        bit          stop;
        bit          bad;

        cmdA = 38'h11_22334455;
        cmdB = 38'h2C_CAFEF00D;
        bus.iReq = 2'b00;
        bus.iCmd0 = '0;
        bus.iCmd1 = '0;
        bus.iAck_out = 1'b0;
        bus.iCommand_timeout = 1'b0;
        bus.iResponse = '0;

        // Power-on reset state
        tick();
        tick();
        chk("por_grant", 64'(bus.oGrant), 64'd0);
        chk("por_done", 64'(bus.oDone), 64'd0);
        chk("por_strobe", 64'(bus.oStrobe_in), 64'd0);
        chk("por_misc", 64'({bus.oTimeout, bus.oAck_in, bus.oIdle_in}), 64'd0);
        chk("por_response", 64'(bus.oResponse), 64'd0);
        chk("por_command", 64'(bus.oCommand), 64'd0);

        // T1: reset held 4 cycles in the middle of ISSUE
        rst = 1'b0;
        bus.iReq = 2'b01;
        bus.iCmd0 = 38'h15_12345678;
        tick();
        tick();
        chk("t1_strobe_before_reset", 64'(bus.oStrobe_in), 64'd1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("t1_strobe", 64'(bus.oStrobe_in), 64'd0);
        chk("t1_grant", 64'(bus.oGrant), 64'd0);
        chk("t1_command", 64'(bus.oCommand), 64'd0);
        chk("t1_ack_idle", 64'({bus.oAck_in, bus.oIdle_in}), 64'd0);
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (bus.oDone !== 2'b00) bad = 1'b1;
            tick();
        end
        if (bus.oDone !== 2'b00) bad = 1'b1;
        chk("t1_no_done", 64'(bad), 64'd0);
        rst = 1'b0;
        bus.iReq = 2'b00;
        tick();
        chk("t1_idle_no_grant", 64'(bus.oGrant), 64'd0);

        // T3: both requesting continuously -> 0,1,0,1
        bus.iCmd0 = cmdA;
        bus.iCmd1 = cmdB;
        bus.iReq  = 2'b11;
        serve("t3_a", 2'b01, cmdA, 38'h01_00000001);
        serve("t3_b", 2'b10, cmdB, 38'h02_00000002);
        serve("t3_c", 2'b01, cmdA, 38'h03_00000003);
        serve("t3_d", 2'b10, cmdB, 38'h04_00000004);
        bus.iReq = 2'b00;
        tick();
        chk("t3_done_cleared", 64'(bus.oDone), 64'd0);

        // T2: exact latency of a single requester-0 transaction
        bus.iReq  = 2'b01;
        bus.iCmd0 = 38'h0A_DEADBEEF;
        tick();
        chk("t2_grant", 64'(bus.oGrant), 64'd1);
        chk("t2_command", 64'(bus.oCommand), 64'h0A_DEADBEEF);
        chk("t2_strobe_not_yet", 64'(bus.oStrobe_in), 64'd0);
        tick();
        chk("t2_strobe", 64'(bus.oStrobe_in), 64'd1);
        bad = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (bus.oStrobe_in !== 1'b1 || bus.oDone !== 2'b00) bad = 1'b1;
        end
        chk("t2_strobe_held", 64'(bad), 64'd0);
        bus.iAck_out  = 1'b1;
        bus.iResponse = 38'd7;
        tick();
        chk("t2_response", 64'(bus.oResponse), 64'd7);
        chk("t2_ack_in_not_yet", 64'(bus.oAck_in), 64'd0);
        tick();
        chk("t2_release", 64'({bus.oStrobe_in, bus.oAck_in}), 64'b01);
        tick();
        chk("t2_ack_in_held", 64'(bus.oAck_in), 64'd1);
        bus.iAck_out = 1'b0;
        tick();
        chk("t2_ack_in_drop", 64'(bus.oAck_in), 64'd0);
        chk("t2_done_not_yet", 64'(bus.oDone), 64'd0);
        tick();
        chk("t2_done", 64'(bus.oDone), 64'd1);
        chk("t2_timeout", 64'(bus.oTimeout), 64'd0);
        chk("t2_grant_cleared", 64'(bus.oGrant), 64'd0);
        chk("t2_response_held", 64'(bus.oResponse), 64'd7);
        bus.iReq = 2'b00;
        tick();
        chk("t2_done_pulse", 64'(bus.oDone), 64'd0);

        // T5: phy silent, watchdog abort after 16 strobe cycles
        bus.iReq  = 2'b10;
        bus.iCmd1 = 38'h3E_0BADF00D;
        waitStrobe("t5");
        chk("t5_grant", 64'(bus.oGrant), 64'b10);
        cnt  = 1;
        stop = 1'b0;
        for (int i = 0; i < 40 && !stop; i++) begin
            tick();
            if (bus.oStrobe_in === 1'b1) cnt++;
            else stop = 1'b1;
        end
        chk("t5_strobe_cycles", 64'(cnt), 64'd16);
        chk("t5_idle_pulse", 64'(bus.oIdle_in), 64'd1);
        chk("t5_no_done_yet", 64'(bus.oDone), 64'd0);
        tick();
        chk("t5_idle_one_cycle", 64'(bus.oIdle_in), 64'd0);
        chk("t5_done", 64'(bus.oDone), 64'b10);
        chk("t5_timeout", 64'(bus.oTimeout), 64'd1);
        chk("t5_response", 64'(bus.oResponse), 64'd0);
        bus.iReq = 2'b01;
        serve("t5_next", 2'b01, 38'h0A_DEADBEEF, 38'h12_3456789A);

        // T4: timeout and ack together, requester 0 re-requests back-to-back
        waitStrobe("t4");
        bus.iCommand_timeout = 1'b1;
        bus.iAck_out         = 1'b1;
        bus.iResponse        = 38'h2A_AAAA5555;
        tick();
        chk("t4_response_zero", 64'(bus.oResponse), 64'd0);
        tick();
        chk("t4_release", 64'({bus.oStrobe_in, bus.oAck_in}), 64'b01);
        bus.iCommand_timeout = 1'b0;
        bus.iAck_out         = 1'b0;
        tick();
        chk("t4_ack_in_drop", 64'(bus.oAck_in), 64'd0);
        tick();
        chk("t4_done", 64'(bus.oDone), 64'd1);
        chk("t4_timeout", 64'(bus.oTimeout), 64'd1);
        chk("t4_response", 64'(bus.oResponse), 64'd0);
        bus.iReq = 2'b00;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.oDone !== 2'b00) cnt++;
        end
        chk("t4_single_pulse", 64'(cnt), 64'd0);

        // T6: requester 1 withdraws mid-ISSUE; transaction still completes
        bus.iReq  = 2'b10;
        bus.iCmd1 = 38'h07_00C0FFEE;
        waitStrobe("t6");
        chk("t6_grant", 64'(bus.oGrant), 64'b10);
        chk("t6_command", 64'(bus.oCommand), 64'h07_00C0FFEE);
        bus.iReq = 2'b00;
        tick();
        tick();
        tick();
        chk("t6_strobe_kept", 64'(bus.oStrobe_in), 64'd1);
        complete("t6", 2'b10, 38'h01_00000055);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.oGrant !== 2'b00 || bus.oStrobe_in !== 1'b0) bad = 1'b1;
        end
        chk("t6_no_regrant", 64'(bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
